button_event_ctrl: RTL and testbench

Multi-channel push-button front end that replaces the single-button reset edge latch. Each channel synchronises an asynchronous button input, debounces it, detects the configured edge, and drives a one-cycle pulse plus a sticky event flag that can be cleared. It sits between the board push-buttons and the control logic, clocked from the PLL output.

---
 rtl/button_event_ctrl.sv | 109 ++++++++++
 tb/tb_button_event_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_event_ctrl.sv
// Multi-channel push-button front end: synchroniser, debounce, edge detect and sticky event flag.
// Define BUTTON_EVENT_COUNT_EN to add per-channel saturating 8-bit event counters (event_count port).
module button_event_ctrl #(
  parameter int CHANNELS        = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int EDGE_MODE       = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [CHANNELS-1:0]   btn_in,
  input  logic [CHANNELS-1:0]   clear,
  output logic [CHANNELS-1:0]   btn_level,
  output logic [CHANNELS-1:0]   edge_pulse,
  output logic [CHANNELS-1:0]   event_latched
`ifdef BUTTON_EVENT_COUNT_EN
  ,
  output logic [8*CHANNELS-1:0] event_count
`endif
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_w;
    logic                   stable_q, stable_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   pulse_q, pulse_d;
    logic                   latched_q, latched_d;
    logic                   edge_match_w;

    assign sync_w = sync_q[SYNC_STAGES-1];

    // Qualify the level about to be accepted against the configured edge polarity.
    assign edge_match_w = (EDGE_MODE == 2) ||
                          ((EDGE_MODE == 0) && sync_w) ||
                          ((EDGE_MODE == 1) && !sync_w);

    always_comb begin
      stable_d = stable_q;
      cnt_d    = '0;
      pulse_d  = 1'b0;
      if (sync_w != stable_q) begin
        if (cnt_q == CNT_LAST) begin
          stable_d = sync_w;
          pulse_d  = edge_match_w;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    // Set wins over clear so an event arriving with a clear is never lost.
    always_comb begin
      latched_d = latched_q;
      if (pulse_q) begin
        latched_d = 1'b1;
      end else if (clear[ch]) begin
        latched_d = 1'b0;
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        sync_q    <= '0;
        stable_q  <= 1'b0;
        cnt_q     <= '0;
        pulse_q   <= 1'b0;
        latched_q <= 1'b0;
      end else begin
        sync_q    <= {sync_q[SYNC_STAGES-2:0], btn_in[ch]};
        stable_q  <= stable_d;
        cnt_q     <= cnt_d;
        pulse_q   <= pulse_d;
        latched_q <= latched_d;
      end
    end

    assign btn_level[ch]     = stable_q;
    assign edge_pulse[ch]    = pulse_q;
    assign event_latched[ch] = latched_q;

`ifdef BUTTON_EVENT_COUNT_EN
    logic [7:0] evcnt_q, evcnt_d;

    always_comb begin
      evcnt_d = evcnt_q;
      if (clear[ch]) begin
        evcnt_d = pulse_q ? 8'd1 : 8'd0;
      end else if (pulse_q && (evcnt_q != 8'hFF)) begin
        evcnt_d = evcnt_q + 8'd1;
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        evcnt_q <= 8'd0;
      end else begin
        evcnt_q <= evcnt_d;
      end
    end

    assign event_count[8*ch +: 8] = evcnt_q;
`endif
  end

endmodule

// File: tb/tb_button_event_ctrl.sv
// Bench for button_event_ctrl: four instances (default, and D=4 with rising/falling/both edges)
// share stimulus; directed vectors plus random traffic against a sliding-window reference model.
module tb_button_event_ctrl;
  localparam int NI = 4;
  localparam int CH = 4;
  localparam int S  = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] btn, clr;
  logic [3:0] lvl_w [NI];
  logic [3:0] pls_w [NI];
  logic [3:0] lat_w [NI];
`ifdef BUTTON_EVENT_COUNT_EN
  logic [31:0] cnt_w [NI];
`endif

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    button_event_ctrl #(
      .CHANNELS       (CH),
      .SYNC_STAGES    (S),
      .DEBOUNCE_CYCLES((gi == 0) ? 16 : 4),
      .EDGE_MODE      ((gi == 0) ? 0 : gi - 1)
    ) u_dut (
      .clk          (clk),
      .reset        (reset),
      .btn_in       (btn),
      .clear        (clr),
      .btn_level    (lvl_w[gi]),
      .edge_pulse   (pls_w[gi]),
      .event_latched(lat_w[gi])
`ifdef BUTTON_EVENT_COUNT_EN
      ,
      .event_count  (cnt_w[gi])
`endif
    );
  end

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic int d_of(int i);
    return (i == 0) ? 16 : 4;
  endfunction

  function automatic int mode_of(int i);
    return (i == 0) ? 0 : i - 1;
  endfunction

  // Reference model: a level is accepted at edge n when the synchronised input seen at
  // each of the last D edges differed from the current level (and no reset intervened).
  logic [3:0] hist [0:16383];
  int         cyc = 0;
  int         rst_cyc = 0;
  logic [3:0] m_lvl [NI];
  logic [3:0] m_pls [NI];
  logic [3:0] m_lat [NI];
  logic [7:0] m_cnt [NI][CH];

  function automatic logic hval(int j, int c);
    if (j < 1 || j <= rst_cyc) return 1'b0;
    return hist[j][c];
  endfunction

  task automatic step_model();
    logic old_p, acc, nl;
    int   d, md;
    cyc++;
    if (!reset) begin
      rst_cyc   = cyc;
      hist[cyc] = '0;
      for (int i = 0; i < NI; i++) begin
        m_lvl[i] = '0; m_pls[i] = '0; m_lat[i] = '0;
        for (int c = 0; c < CH; c++) m_cnt[i][c] = 8'd0;
      end
      return;
    end
    hist[cyc] = btn;
    for (int i = 0; i < NI; i++) begin
      d  = d_of(i);
      md = mode_of(i);
      for (int c = 0; c < CH; c++) begin
        old_p = m_pls[i][c];
        acc   = 1'b1;
        for (int k = 0; k < d; k++) begin
          if (cyc - k <= rst_cyc) acc = 1'b0;
          else if (hval(cyc - k - S, c) == m_lvl[i][c]) acc = 1'b0;
        end
        m_pls[i][c] = 1'b0;
        if (acc) begin
          nl          = ~m_lvl[i][c];
          m_lvl[i][c] = nl;
          m_pls[i][c] = (md == 2) || (md == 0 && nl) || (md == 1 && !nl);
        end
        if (old_p) m_lat[i][c] = 1'b1;
        else if (clr[c]) m_lat[i][c] = 1'b0;
        if (clr[c]) m_cnt[i][c] = old_p ? 8'd1 : 8'd0;
        else if (old_p && m_cnt[i][c] != 8'd255) m_cnt[i][c] = m_cnt[i][c] + 8'd1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    step_model();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cmp_model();
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("model btn_level inst%0d cyc%0d", i, cyc), 32'(lvl_w[i]), 32'(m_lvl[i]));
      chk($sformatf("model edge_pulse inst%0d cyc%0d", i, cyc), 32'(pls_w[i]), 32'(m_pls[i]));
      chk($sformatf("model event_latched inst%0d cyc%0d", i, cyc), 32'(lat_w[i]), 32'(m_lat[i]));
`ifdef BUTTON_EVENT_COUNT_EN
      for (int c = 0; c < CH; c++)
        chk($sformatf("model event_count inst%0d ch%0d", i, c), 32'(cnt_w[i][8*c +: 8]), 32'(m_cnt[i][c]));
`endif
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    btn   = '0;
    clr   = '0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  typedef struct {
    logic [3:0] btn;
    logic [3:0] clr;
    int         n;
    logic [3:0] lvl;
    logic [3:0] pls;
    logic [3:0] lat;
  } vec_t;

  vec_t tbl [8];

  initial begin
    int pc1, pc2, pc3, t;
    logic seen, any_out;

    tbl[0] = '{4'b0001, 4'b0000, 17, 4'b0000, 4'b0000, 4'b0000};
    tbl[1] = '{4'b0001, 4'b0000,  1, 4'b0001, 4'b0001, 4'b0000};
    tbl[2] = '{4'b0001, 4'b0000,  1, 4'b0001, 4'b0000, 4'b0001};
    tbl[3] = '{4'b0001, 4'b0000,  5, 4'b0001, 4'b0000, 4'b0001};
    tbl[4] = '{4'b0000, 4'b0001,  1, 4'b0001, 4'b0000, 4'b0000};
    tbl[5] = '{4'b0000, 4'b0000, 16, 4'b0001, 4'b0000, 4'b0000};
    tbl[6] = '{4'b0000, 4'b0000,  1, 4'b0000, 4'b0000, 4'b0000};
    tbl[7] = '{4'b0110, 4'b0000, 20, 4'b0110, 4'b0000, 4'b0110};

    reset = 1'b0;
    btn   = '0;
    clr   = '0;
    #1;
    chk("reset btn_level", 32'(lvl_w[0]), 32'h0);
    chk("reset edge_pulse", 32'(pls_w[0]), 32'h0);
    chk("reset event_latched", 32'(lat_w[0]), 32'h0);
    do_reset();

    // Table vectors on the default instance; first edge after release is edge 1.
    for (int r = 0; r < 8; r++) begin
      btn = tbl[r].btn;
      clr = tbl[r].clr;
      repeat (tbl[r].n) tick();
      chk($sformatf("tbl%0d btn_level", r), 32'(lvl_w[0]), 32'(tbl[r].lvl));
      chk($sformatf("tbl%0d edge_pulse", r), 32'(pls_w[0]), 32'(tbl[r].pls));
      chk($sformatf("tbl%0d event_latched", r), 32'(lat_w[0]), 32'(tbl[r].lat));
    end

    // Glitch of 3 cycles on D=4 is discarded; 4 cycles is accepted once.
    do_reset();
    seen = 1'b0;
    btn  = 4'b0010;
    repeat (3) begin tick(); seen |= lvl_w[1][1] | pls_w[1][1] | lat_w[1][1]; end
    btn = 4'b0000;
    repeat (12) begin tick(); seen |= lvl_w[1][1] | pls_w[1][1] | lat_w[1][1]; end
    chk("glitch3 ch1 outputs", 32'(seen), 32'h0);
    seen = 1'b0;
    pc1  = 0;
    btn  = 4'b0010;
    repeat (4) begin tick(); seen |= lvl_w[1][1]; pc1 += int'(pls_w[1][1]); end
    btn = 4'b0000;
    repeat (12) begin tick(); seen |= lvl_w[1][1]; pc1 += int'(pls_w[1][1]); end
    chk("minwidth4 level seen", 32'(seen), 32'h1);
    chk("minwidth4 pulses", 32'(pc1), 32'd1);

    // Press/release ch2 for 30 cycles each across the three edge modes.
    do_reset();
    pc1 = 0; pc2 = 0; pc3 = 0; seen = 1'b0;
    btn = 4'b0100;
    repeat (30) begin
      tick();
      pc1 += int'(pls_w[1][2]); pc2 += int'(pls_w[2][2]); pc3 += int'(pls_w[3][2]);
    end
    chk("falling mode no pulse on press", 32'(pc2), 32'd0);
    btn = 4'b0000;
    repeat (30) begin
      tick();
      pc1 += int'(pls_w[1][2]); pc2 += int'(pls_w[2][2]); pc3 += int'(pls_w[3][2]);
      if (pls_w[2][2]) seen |= lvl_w[2][2];
    end
    chk("rising mode pulses", 32'(pc1), 32'd1);
    chk("falling mode pulses", 32'(pc2), 32'd1);
    chk("falling pulse level low", 32'(seen), 32'h0);
    chk("both mode pulses", 32'(pc3), 32'd2);

    // Clear coinciding with a new edge_pulse on ch3 (both-edge instance).
    do_reset();
    btn = 4'b1000;
    for (t = 0; t < 20 && !pls_w[3][3]; t++) tick();
    chk("ch3 press pulse", 32'(pls_w[3][3]), 32'h1);
    tick();
    chk("ch3 latched", 32'(lat_w[3][3]), 32'h1);
    btn = 4'b0000;
    for (t = 0; t < 20 && !pls_w[3][3]; t++) tick();
    chk("ch3 release pulse", 32'(pls_w[3][3]), 32'h1);
    clr = 4'b1000;
    tick();
    chk("set wins over clear", 32'(lat_w[3][3]), 32'h1);
    tick();
    chk("clear alone", 32'(lat_w[3][3]), 32'h0);
    clr = 4'b0000;

    // Reset in the middle of a debounce on the default instance.
    do_reset();
    btn = 4'b0001;
    repeat (12) tick();
    chk("mid-debounce level", 32'(lvl_w[0]), 32'h0);
    chk("d4 accepted before reset", 32'(lvl_w[1]), 32'h1);
    reset = 1'b0;
    #1;
    any_out = 1'b0;
    for (int i = 0; i < NI; i++) any_out |= (|lvl_w[i]) | (|pls_w[i]) | (|lat_w[i]);
    chk("async reset clears outputs", 32'(any_out), 32'h0);
    tick();
    reset = 1'b1;
    pc1   = 0;
    repeat (17) begin tick(); pc1 += int'(pls_w[0][0]); end
    chk("post-reset level edge17", 32'(lvl_w[0][0]), 32'h0);
    tick();
    pc1 += int'(pls_w[0][0]);
    chk("post-reset level edge18", 32'(lvl_w[0][0]), 32'h1);
    repeat (5) begin tick(); pc1 += int'(pls_w[0][0]); end
    chk("post-reset pulses", 32'(pc1), 32'd1);

`ifdef BUTTON_EVENT_COUNT_EN
    do_reset();
    for (int e = 0; e < 300; e++) begin
      btn = 4'b0001; repeat (5) tick();
      btn = 4'b0000; repeat (5) tick();
    end
    chk("event_count saturates", 32'(cnt_w[1][7:0]), 32'd255);
    clr = 4'b0001;
    tick();
    clr = 4'b0000;
    chk("event_count clear", 32'(cnt_w[1][7:0]), 32'd0);
`endif

    // Random traffic with slow and fast phases, random clears and occasional resets.
    do_reset();
    for (int n = 0; n < 800; n++) begin
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, ((n / 100) % 2 == 0) ? 39 : 3) == 0) btn[c] = ~btn[c];
        clr[c] = ($urandom_range(0, 11) == 0);
      end
      reset = ($urandom_range(0, 299) != 0);
      tick();
      cmp_model();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
